// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button press classifier: state encoding and
// default timing constants derived from the 100 MHz debouncer clock basis.
package button_press_classifier_pkg;

    // Clock basis shared with the upstream pushbutton debouncer.
    localparam int CLK_FREQ_HZ   = 100_000_000;
    localparam int CYCLES_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int DEBOUNCE_MS   = 10;

    // Long-press threshold is 500 ms, auto-repeat period is 100 ms,
    // both expressed as multiples of the debounce window.
    localparam int LONG_MS   = 50 * DEBOUNCE_MS;
    localparam int REPEAT_MS = 10 * DEBOUNCE_MS;

    localparam int DEFAULT_LONG_CYCLES   = LONG_MS * CYCLES_PER_MS;
    localparam int DEFAULT_REPEAT_CYCLES = REPEAT_MS * CYCLES_PER_MS;
    localparam int DEFAULT_CNT_W         = 26;

    // State encoding.
    localparam logic [1:0] IDLE_ENC    = 2'd0;
    localparam logic [1:0] PRESSED_ENC = 2'd1;
    localparam logic [1:0] REPEAT_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE_ENC,
        ST_PRESSED = PRESSED_ENC,
        ST_REPEAT  = REPEAT_ENC
    } state_t;

endpackage

// File: rtl/button_press_classifier_rise_detect.sv
// Rising-edge detector on the debounced level. The previous-sample register
// loads the live input during reset, so a button already held through reset
// does not look like a new press once reset is released.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev_reg;

    // Track the last sampled level; reset captures the current level rather
    // than 0 so a held button produces no edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_reg <= din;
        end else begin
            prev_reg <= din;
        end
    end

    // New press: high now, low on the previous sample.
    assign rise = din & ~prev_reg;

endmodule

// File: rtl/button_press_classifier.sv
// Converts a debounced button level into single-cycle event pulses:
// press, short press, long press and auto-repeat, plus a registered held
// flag. All outputs come straight from flops.
module button_press_classifier
    import button_press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic clean,
    output logic press_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    // Terminal counts for the hold counter in each timed state.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             rise;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic             press_next;
    logic             short_next;
    logic             long_next;
    logic             repeat_next;
    logic             held_next;

    logic             press_reg;
    logic             short_reg;
    logic             long_reg;
    logic             repeat_reg;
    logic             held_reg;

    rise_detect u_rise_detect (
        .clock (clock),
        .reset (reset),
        .din   (clean),
        .rise  (rise)
    );

    // Next-state, hold counter and pulse decode. Release is tested before
    // any threshold so a release on the threshold edge never emits a
    // long/repeat pulse, which also keeps the four pulses mutually exclusive.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        press_next  = 1'b0;
        short_next  = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    state_next = ST_PRESSED;
                    count_next = '0;
                    press_next = 1'b1;
                end
            end

            ST_PRESSED: begin
                if (!clean) begin
                    state_next = ST_IDLE;
                    short_next = 1'b1;
                end else if (count_reg == LONG_LAST) begin
                    state_next = ST_REPEAT;
                    count_next = '0;
                    long_next  = 1'b1;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end

            ST_REPEAT: begin
                if (!clean) begin
                    // Release after a long press is silent.
                    state_next = ST_IDLE;
                end else if (count_reg == REPEAT_LAST) begin
                    count_next  = '0;
                    repeat_next = 1'b1;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end

            default: begin
                // Unused encoding: recover to idle quietly.
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase

        // held reflects the state being entered so it lines up with the
        // registered pulses.
        held_next = (state_next != ST_IDLE);
    end

    // State, counter and output registers. Reset forces idle with every
    // output low, which also drops any press in progress without a pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            press_reg  <= 1'b0;
            short_reg  <= 1'b0;
            long_reg   <= 1'b0;
            repeat_reg <= 1'b0;
            held_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            press_reg  <= press_next;
            short_reg  <= short_next;
            long_reg   <= long_next;
            repeat_reg <= repeat_next;
            held_reg   <= held_next;
        end
    end

    assign press_pulse  = press_reg;
    assign short_press  = short_reg;
    assign long_press   = long_reg;
    assign repeat_pulse = repeat_reg;
    assign held         = held_reg;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with LONG_CYCLES=8 and
// REPEAT_CYCLES=4. Each step drives one cycle of input, queues the output
// vector expected in the following cycle, then pops and checks it.
// Vector layout: {press_pulse, short_press, long_press, repeat_pulse, held}.
module tb_button_press_classifier;

    localparam int L = 8;
    localparam int R = 4;

    logic clock;
    logic reset;
    logic clean;
    logic press_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    int compared;
    int mismatched;

    button_press_classifier #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R),
        .CNT_W         (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clean        (clean),
        .press_pulse  (press_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs in cycle T+j for the j-th consecutive high sample of a
    // press that started from a low previous sample.
    function automatic logic [4:0] exp_hold(input int j);
        logic p, lg, rp;
        p  = (j == 0);
        lg = (j == L);
        rp = (j > L) && (((j - L) % R) == 0);
        return {p, 1'b0, lg, rp, 1'b1};
    endfunction

    // Drive one cycle, queue its expected result, then check the output
    // produced by that edge one time unit after it.
    task automatic step(input logic c, input logic r, input logic [4:0] e, input string tag);
        logic [4:0] obs;
        logic [4:0] expv;
        string      t;
        clean = c;
        reset = r;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        obs  = {press_pulse, short_press, long_press, repeat_pulse, held};
        expv = exp_q.pop_front();
        t    = tag_q.pop_front();
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s t=%0t observed=%b expected=%b", t, $time, obs, expv);
        end
    endtask

    // Press held for h samples then released for lows samples.
    task automatic press_seq(input int h, input int lows, input string tag);
        for (int j = 0; j < h; j++) begin
            step(1'b1, 1'b0, exp_hold(j), tag);
        end
        for (int k = 0; k < lows; k++) begin
            step(1'b0, 1'b0, {1'b0, (k == 0) && (h <= L), 3'b000}, tag);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        clean      = 1'b0;
        reset      = 1'b1;

        // Reset state.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'b00000, "reset_state");

        // 1: button held through reset gives nothing until re-pressed.
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 5'b00000, "held_in_reset");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 5'b00000, "held_after_reset");
        step(1'b0, 1'b0, 5'b00000, "held_drop");
        press_seq(3, 2, "repress_after_reset");

        // 2: short press.
        press_seq(5, 3, "short_press");

        // 3: long press with repeats.
        press_seq(20, 3, "long_repeat");

        // 4: threshold boundary.
        press_seq(8, 3, "boundary_8");
        press_seq(9, 3, "boundary_9");

        // 5: reset while in REPEAT, then a silent release.
        for (int j = 0; j < 15; j++) step(1'b1, 1'b0, exp_hold(j), "mid_repeat");
        step(1'b1, 1'b1, 5'b00000, "mid_reset");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5'b00000, "post_reset_hold");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'b00000, "post_reset_release");

        // 6: back-to-back presses separated by a single low cycle.
        press_seq(3, 1, "b2b_first");
        press_seq(3, 2, "b2b_second");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
